// File: rtl/frame_packer_3c1s_18x18.sv
// Packs WORD_W-bit words into a NUM_GROUPS-slot frame for the encoder array.
// A fill buffer collects words while a second register presents the previous frame.
module frame_packer_3c1s_18x18 #(
  parameter int WORD_W     = 11,
  parameter int NUM_GROUPS = 20,
  localparam int FRAME_W   = WORD_W * NUM_GROUPS,
  localparam int CNT_W     = $clog2(NUM_GROUPS + 1)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  input  logic               frame_ack,
  output logic [CNT_W-1:0]   frame_len,
  output logic [15:0]        stat_frames
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_GROUPS);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic [FRAME_W-1:0] fill_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] frame_q;
  logic [CNT_W-1:0]   len_q;
  logic               vld_q;
  logic [15:0]        stat_q;

  logic               accept;
  logic               ack_evt;
  logic               slot_free;
  logic [CNT_W-1:0]   cnt_d;
  logic [FRAME_W-1:0] fill_d;

  // Buffer and count as they stand after this edge's accept, if any.
  always_comb begin
    accept    = in_valid && (state_q == S_FILL);
    ack_evt   = vld_q && frame_ack;
    slot_free = !vld_q || frame_ack;
    cnt_d     = cnt_q + CNT_W'(accept);
    fill_d    = fill_q;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      if (accept && (cnt_q == CNT_W'(k))) begin
        fill_d[k*WORD_W +: WORD_W] = in_data;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      len_q   <= '0;
      vld_q   <= 1'b0;
      stat_q  <= '0;
    end else begin
      if (ack_evt) begin
        vld_q  <= 1'b0;
        stat_q <= stat_q + 16'd1;
      end
      case (state_q)
        S_FILL: begin
          fill_q <= fill_d;
          cnt_q  <= cnt_d;
          if ((cnt_d == FULL) || (flush && (cnt_d != '0))) begin
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          // A transfer on an ack edge overrides the clear above.
          if (slot_free) begin
            frame_q <= fill_q;
            len_q   <= cnt_q;
            vld_q   <= 1'b1;
            fill_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready    = (state_q == S_FILL);
  assign frame_out   = frame_q;
  assign frame_valid = vld_q;
  assign frame_len   = len_q;
  assign stat_frames = stat_q;

endmodule

// File: tb/tb_frame_packer_3c1s_18x18.sv
// Self-checking bench for frame_packer_3c1s_18x18: directed scenarios plus
// randomized traffic compared against a queue-based frame model.
module tb_frame_packer_3c1s_18x18;
  localparam int WORD_W = 11;
  localparam int NG     = 20;
  localparam int FW     = WORD_W * NG;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [FW-1:0]     frame_out;
  logic              frame_valid;
  logic              frame_ack;
  logic [4:0]        frame_len;
  logic [15:0]       stat_frames;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  frame_packer_3c1s_18x18 #(.WORD_W(WORD_W), .NUM_GROUPS(NG)) dut (
    .clock(clock), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_len(frame_len),
    .stat_frames(stat_frames)
  );

  // Reference model: words of the frame being built, a "frame pending" flag,
  // and the frame currently presented downstream.
  logic [WORD_W-1:0] m_cur[$];
  bit                m_hold;
  bit                m_ov;
  logic [FW-1:0]     m_out;
  int                m_len;
  logic [15:0]       m_stat;

  function automatic void model_reset();
    m_cur.delete();
    m_hold = 0;
    m_ov   = 0;
    m_out  = '0;
    m_len  = 0;
    m_stat = '0;
  endfunction

  function automatic logic [FW-1:0] pack_cur();
    logic [FW-1:0] r;
    r = '0;
    foreach (m_cur[i]) r[i*WORD_W +: WORD_W] = m_cur[i];
    return r;
  endfunction

  function automatic void model_edge(bit v, logic [WORD_W-1:0] d, bit f, bit a);
    bit old_ov;
    bit tx;
    old_ov = m_ov;
    tx     = 0;
    if (m_hold) begin
      if (!m_ov || a) begin
        m_out  = pack_cur();
        m_len  = m_cur.size();
        m_cur.delete();
        m_hold = 0;
        tx     = 1;
      end
    end else begin
      if (v) m_cur.push_back(d);
      if (m_cur.size() == NG || (f && m_cur.size() >= 1)) m_hold = 1;
    end
    if (tx) m_ov = 1;
    else if (old_ov && a) m_ov = 0;
    if (old_ov && a) m_stat = m_stat + 16'd1;
  endfunction

  task automatic step(input bit v, input logic [WORD_W-1:0] d, input bit f, input bit a);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    frame_ack = a;
    @(posedge clock);
    model_edge(v, d, f, a);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    frame_ack = 1'b0;
    model_reset();
    #2;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; frame_ack = 1'b0;
    model_reset();
    #1;
    n_checks++; if (frame_out !== '0) begin n_fail++; $display("FAIL reset_frame_out got %h want 0", frame_out); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
    n_checks++; if (frame_len !== 5'd0) begin n_fail++; $display("FAIL reset_frame_len got %0d want 0", frame_len); end
    n_checks++; if (stat_frames !== 16'd0) begin n_fail++; $display("FAIL reset_stat got %0d want 0", stat_frames); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int k = 0; k < NG; k++) step(1'b1, 11'(k + 1), 1'b0, 1'b1);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_early got %b want 0", frame_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_hold got %b want 0", in_ready); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", frame_valid); end
    n_checks++; if (frame_out[10:0] !== 11'h001) begin n_fail++; $display("FAIL full_slot0 got %h want 001", frame_out[10:0]); end
    n_checks++; if (frame_out[219:209] !== 11'h014) begin n_fail++; $display("FAIL full_slot19 got %h want 014", frame_out[219:209]); end
    n_checks++; if (frame_len !== 5'd20) begin n_fail++; $display("FAIL full_len got %0d want 20", frame_len); end
    n_checks++; if (frame_out !== m_out) begin n_fail++; $display("FAIL full_frame got %h want %h", frame_out, m_out); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (stat_frames !== 16'd1) begin n_fail++; $display("FAIL full_stat got %0d want 1", stat_frames); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_clear got %b want 0", frame_valid); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] first_exp;
    int accepted;
    int cyc;
    bit rdy;
    do_reset();
    first_exp = '0;
    for (int i = 0; i < NG; i++) first_exp[i*WORD_W +: WORD_W] = 11'(i + 1);
    accepted = 0;
    cyc = 0;
    while (accepted < 40 && cyc < 200) begin
      rdy = in_ready;
      step(1'b1, 11'(accepted + 1), 1'b0, 1'b0);
      if (rdy) accepted++;
      if (frame_valid) begin
        n_checks++;
        if (frame_out !== first_exp) begin n_fail++; $display("FAIL bp_stable got %h want %h", frame_out, first_exp); end
      end
      cyc++;
    end
    n_checks++; if (accepted != 40) begin n_fail++; $display("FAIL bp_timeout accepted %0d want 40", accepted); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
    n_checks++; if (frame_len !== 5'd20) begin n_fail++; $display("FAIL bp_len got %0d want 20", frame_len); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_kept got %b want 1", frame_valid); end
    n_checks++; if (frame_out[10:0] !== 11'h015) begin n_fail++; $display("FAIL bp_slot0_second got %h want 015", frame_out[10:0]); end
    n_checks++; if (frame_out !== m_out) begin n_fail++; $display("FAIL bp_second_frame got %h want %h", frame_out, m_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
    n_checks++; if (stat_frames !== 16'd1) begin n_fail++; $display("FAIL bp_stat got %0d want 1", stat_frames); end
  endtask

  task automatic test_flush();
    logic [FW-1:0] exp;
    do_reset();
    exp = '0;
    exp[32:0] = '1;
    for (int k = 0; k < 3; k++) step(1'b1, 11'h7FF, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_early got %b want 0", frame_valid); end
    step(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b want 1", frame_valid); end
    n_checks++; if (frame_len !== 5'd3) begin n_fail++; $display("FAIL flush_len got %0d want 3", frame_len); end
    n_checks++; if (frame_out !== exp) begin n_fail++; $display("FAIL flush_frame got %h want %h", frame_out, exp); end
  endtask

  task automatic test_flush_edge();
    logic [FW-1:0] exp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got %b want 0", frame_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready got %b want 1", in_ready); end
    end
    step(1'b1, 11'h5A5, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    exp = '0;
    exp[10:0] = 11'h5A5;
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL flush_same_valid got %b want 1", frame_valid); end
    n_checks++; if (frame_len !== 5'd1) begin n_fail++; $display("FAIL flush_same_len got %0d want 1", frame_len); end
    n_checks++; if (frame_out !== exp) begin n_fail++; $display("FAIL flush_same_frame got %h want %h", frame_out, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < NG; k++) step(1'b1, 11'(k + 3), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b1, 11'(k + 40), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (frame_out !== '0) begin n_fail++; $display("FAIL rmid_frame_out got %h want 0", frame_out); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", frame_valid); end
    n_checks++; if (frame_len !== 5'd0) begin n_fail++; $display("FAIL rmid_len got %0d want 0", frame_len); end
    n_checks++; if (stat_frames !== 16'd0) begin n_fail++; $display("FAIL rmid_stat got %0d want 0", stat_frames); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", in_ready); end
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < NG; k++) step(1'b1, 11'(12'h100 + k), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (frame_out[10:0] !== 11'h100) begin n_fail++; $display("FAIL rmid_slot0 got %h want 100", frame_out[10:0]); end
    n_checks++; if (frame_len !== 5'd20) begin n_fail++; $display("FAIL rmid_len_after got %0d want 20", frame_len); end
    n_checks++; if (frame_out !== m_out) begin n_fail++; $display("FAIL rmid_frame got %h want %h", frame_out, m_out); end
  endtask

  task automatic test_random();
    bit v, f, a;
    logic [WORD_W-1:0] d;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      v = ($urandom_range(0, 99) < 70);
      f = ($urandom_range(0, 99) < 6);
      a = ($urandom_range(0, 99) < 50);
      d = 11'($urandom);
      step(v, d, f, a);
      n_checks++; if (in_ready !== !m_hold) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, in_ready, !m_hold); end
      n_checks++; if (frame_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, frame_valid, m_ov); end
      n_checks++; if (frame_len !== 5'(m_len)) begin n_fail++; $display("FAIL rnd_len cyc %0d got %0d want %0d", c, frame_len, m_len); end
      n_checks++; if (frame_out !== m_out) begin n_fail++; $display("FAIL rnd_frame cyc %0d got %h want %h", c, frame_out, m_out); end
      n_checks++; if (stat_frames !== m_stat) begin n_fail++; $display("FAIL rnd_stat cyc %0d got %0d want %0d", c, stat_frames, m_stat); end
    end
  endtask

  task automatic test_stat_wrap();
    do_reset();
    step(1'b1, 11'h123, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    force dut.stat_q = 16'hFFFF;
    #1;
    release dut.stat_q;
    m_stat = 16'hFFFF;
    #1;
    n_checks++; if (stat_frames !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", stat_frames); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (stat_frames !== 16'h0000) begin n_fail++; $display("FAIL wrap_stat got %h want 0000", stat_frames); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid got %b want 0", frame_valid); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_flush();
    test_flush_edge();
    test_reset_mid();
    test_random();
    test_stat_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_packer_3c1s_18x18.md
FRAME_PACKER_3C1S_18X18 -- requirements
Module: frame_packer_3c1s_18x18

Interface
REQ-001 SHALL have parameters: WORD_W, 11, width of one data word (one TNS encoding group input).
REQ-002 SHALL have parameter: NUM_GROUPS, 20, words per frame; frame width = WORD_W*NUM_GROUPS = 220.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-low):
  clock  input  1  sole clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  in_data  input  11  data word
  in_valid  input  1  in_data valid
  in_ready  output  1  block can accept a word this cycle
  flush  input  1  emit partially filled frame, zero-padded
  frame_out  output  220  packed frame, drives encoder array datain
  frame_valid  output  1  frame_out holds a frame
  frame_ack  input  1  downstream consumed frame_out
  frame_len  output  5  valid words in frame_out (1..20)
  stat_frames  output  16  count of acknowledged frames

Function
REQ-004 SHALL accept a word on a rising edge when in_valid=1 and in_ready=1; otherwise in_data is ignored.
REQ-005 SHALL write the k-th accepted word of a frame (k=0..19) to fill-buffer bits [11k+10:11k], so word k feeds encoder group k.
REQ-006 SHALL keep an internal fill count 0..20 and two states: FILL (in_ready=1) and HOLD (in_ready=0).
REQ-007 SHALL move FILL->HOLD on the edge that accepts the 20th word.
REQ-008 SHALL move FILL->HOLD on an edge with flush=1 when the fill count after that edge's accept is >=1; a word accepted on the same edge counts toward the frame.
REQ-009 SHALL ignore flush when the fill count after that edge is 0, and SHALL ignore flush in HOLD.
REQ-010 SHALL transfer in HOLD when the output slot is free (frame_valid=0, or frame_valid=1 and frame_ack=1 on the same edge): frame_out<=fill buffer, frame_len<=fill count, frame_valid<=1, fill buffer<=0, fill count<=0, state<=FILL.
REQ-011 SHALL zero unfilled slots of a flushed frame.
REQ-012 SHALL give a latency of exactly one cycle from the edge accepting the last word (or the flush edge) to frame_valid=1 when the output slot is free.
REQ-013 SHALL hold frame_out, frame_len and frame_valid stable while frame_valid=1 and frame_ack=0.
REQ-014 SHALL clear frame_valid on an edge with frame_valid=1 and frame_ack=1 unless a transfer occurs on that same edge, in which case frame_valid stays 1 with the new frame.
REQ-015 SHALL ignore frame_ack while frame_valid=0.
REQ-016 SHALL keep filling the next frame in FILL while a previous frame is held on frame_out, giving double buffering.
REQ-017 SHALL increment stat_frames by 1 modulo 2^16 on every edge with frame_valid=1 and frame_ack=1, wrapping 65535->0.
REQ-018 SHALL drive in_ready combinationally from the state only (1 in FILL, 0 in HOLD), with no dependence on in_valid or frame_ack.

Reset
REQ-019 SHALL on rst_n=0, asynchronously and regardless of clock: frame_out=0, frame_valid=0, frame_len=0, stat_frames=0, fill buffer=0, fill count=0, state=FILL, in_ready=1.
REQ-020 SHALL discard any partial or held frame when reset is asserted mid-operation; the first word after deassertion goes to slot 0.
REQ-021 SHALL accept words from the first rising edge after rst_n deasserts.

Verification
REQ-022 Full frame: frame_ack=1, 20 consecutive words 0x001..0x014 -> frame_valid=1 one cycle after the 20th accept, frame_out[10:0]=0x001, frame_out[219:209]=0x014, frame_len=20, stat_frames=1 after the ack edge.
REQ-023 Backpressure: frame_ack=0, 40 words offered -> the first frame is held stable; in_ready=0 after the 40th accept; one-cycle frame_ack pulse -> the next cycle shows the second frame (slot 0 = word 21), frame_valid stays 1, in_ready=1.
REQ-024 Flush: 3 words 0x7FF, then flush pulse -> frame_len=3, frame_out[32:0] all ones, frame_out[219:33]=0.
REQ-025 Flush on empty buffer, and flush on the same edge as a word accept: empty -> no frame, frame_valid stays 0; same edge -> frame_len=1 with that word in slot 0.
REQ-026 Reset mid-fill after 7 words with a frame held -> all outputs 0, in_ready=1; 20 new words then produce a frame whose slot 0 is the first post-reset word.
REQ-027 stat_frames preloaded to 65535 via 65535 acknowledged frames (or forced) -> one more ack yields 0.
